// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one bit per clock, LSB first.
// Rev 1.0 - initial release.
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             Equal
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic             diff_bit;
   logic             borrow_next;
   logic             last_bit;
   logic [WIDTH-1:0] res_final;

   assign diff_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
   assign borrow_next = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow) | (b_sh[0] & borrow);
   assign last_bit    = (cnt == CW'(WIDTH - 1));
   assign res_final   = {diff_bit, res_sh[WIDTH-1:1]};

   assign Busy = (state != IDLE);
   assign Done = (state == DONE);

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Published outputs load only on the last shift so partial results never show on D.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         D      <= '0;
         Bout   <= 1'b0;
         Equal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  borrow <= Bin;
                  res_sh <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_final;
               borrow <= borrow_next;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  D     <= res_final;
                  Bout  <= borrow_next;
                  Equal <= (res_final == '0) && !borrow_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port ResetN, input, 1 bit, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit, the operation request, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits, the minuend, captured when Start is accepted.
REQ-006 The block SHALL have port B, input, WIDTH bits, the subtrahend, captured when Start is accepted.
REQ-007 The block SHALL have port Bin, input, 1 bit, the initial borrow-in, captured when Start is accepted.
REQ-008 The block SHALL have port Busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit, a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port D, output, WIDTH bits, the difference result.
REQ-011 The block SHALL have port Bout, output, 1 bit, the final borrow-out.
REQ-012 The block SHALL have port Equal, output, 1 bit, high when D is all zeros and Bout is 0.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE with Start=1, the block SHALL capture A, B and Bin into internal shift and borrow registers, clear the bit counter, and go to SHIFT.
- Start is accepted in the same edge.
REQ-015 In SHIFT, each cycle SHALL process one bit, LSB first.
- Difference bit = a XOR b XOR borrow.
- Next borrow = (~a & b) | (~a & borrow) | (b & borrow).
REQ-016 Each SHIFT cycle SHALL shift the difference bit into the MSB of the result register while shifting both operand registers right by one.
REQ-017 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
- Counter reaches WIDTH-1 on the last bit.
REQ-018 In DONE, the block SHALL assert Done for exactly one cycle and return to IDLE on the next edge.
REQ-019 Latency SHALL be WIDTH+1 cycles from the Start-accepting edge to the edge at which Done is observed high.
REQ-020 Busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-021 Start asserted while Busy=1 SHALL be ignored, with no queuing.
REQ-022 Start held high continuously SHALL begin a new operation on the edge at which the FSM is back in IDLE, i.e. one operation per WIDTH+2 cycles.
REQ-023 D, Bout and Equal SHALL update only on the edge entering DONE.
- They hold their value until the next operation completes.
- Intermediate shift contents SHALL NOT be visible on D.
REQ-024 The result SHALL equal A - B - Bin modulo 2^WIDTH.
- Bout=1 exactly when A < B + Bin, unsigned.
REQ-025 Changes on A, B or Bin after capture SHALL NOT affect the operation in progress.

Reset
REQ-026 ResetN=0 SHALL immediately force the FSM to IDLE, regardless of Clock.
- Busy=0, Done=0, D=0, Bout=0, Equal=0.
- Counter and shift registers cleared.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no Done pulse.
- The first operation after reset release SHALL be accepted normally.
REQ-028 Start SHALL be ignored on the first rising edge at which ResetN is low; operation begins only on edges with ResetN=1.

Verification
REQ-029 WIDTH=8, A=0x5A, B=0x3C, Bin=0, Start pulse -> Done after 9 cycles; D=0x1E, Bout=0, Equal=0; Busy high for 9 cycles.
REQ-030 A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, Equal=0 (wrap-around).
REQ-031 A=0x7F, B=0x7F, Bin=0 -> D=0x00, Bout=0, Equal=1; same with Bin=1 -> D=0xFF, Bout=1, Equal=0.
REQ-032 Start re-pulsed at cycles 2 and 5 of a busy operation with different A/B -> ignored; only the original result appears with a single Done.
REQ-033 ResetN driven low at cycle 4 of an operation -> outputs 0 immediately, no Done; next Start with A=0x10, B=0x01 -> D=0x0F.
REQ-034 Start held high for 30 cycles with A=0x03, B=0x01 -> Done pulses every 10 cycles, D=0x02 each time.
